// File: rtl/comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : comp_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one pipelined integer
//            comparator (din1 <= din2) among NUM_REQ tree-node evaluators.
//            Winning operands are registered onto the comparator inputs and
//            a {valid, id} tag travels alongside the comparator pipeline so
//            each result returns to its requester 1 + CMP_LAT cycles after
//            the grant.
// Options  : COMP_ARB_STATS_EN - adds saturating grant_cnt / stall_cnt
//            outputs (32 bits each).
// Revision : 1.0 - initial release
// ============================================================================
module comp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 24,
  parameter int CMP_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_din1,
  input  logic [NUM_REQ*WIDTH-1:0] req_din2,
  output logic [WIDTH-1:0]         cmp_din1,
  output logic [WIDTH-1:0]         cmp_din2,
  input  logic                     cmp_le,
  input  logic [WIDTH-1:0]         cmp_diff,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_le,
  output logic [WIDTH-1:0]         rsp_diff,
`ifdef COMP_ARB_STATS_EN
  output logic [31:0]              grant_cnt,
  output logic [31:0]              stall_cnt,
`endif
  output logic                     busy
);

  localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);
  localparam logic [c_ID_W:0]   c_NUM_EXT = (c_ID_W + 1)'(NUM_REQ);

  // Unpacked views of the per-requester operand buses
  logic [WIDTH-1:0] w_din1_arr [NUM_REQ];
  logic [WIDTH-1:0] w_din2_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_din1_arr[gi] = req_din1[gi*WIDTH +: WIDTH];
      assign w_din2_arr[gi] = req_din2[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Arbitration state and issue registers
  logic [c_ID_W-1:0]  r_rr_ptr;
  logic [WIDTH-1:0]   r_cmp_din1;
  logic [WIDTH-1:0]   r_cmp_din2;

  // Tag pipe: stage 0 is aligned with the registered operands, stage
  // CMP_LAT is aligned with the comparator outputs.
  logic [CMP_LAT:0]   r_tag_vld;
  logic [c_ID_W-1:0]  r_tag_id [CMP_LAT+1];

  // Arbitration intermediates
  logic [c_ID_W:0]    w_scan;
  logic [c_ID_W-1:0]  w_scan_id;
  logic [c_ID_W-1:0]  w_grant_id;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [c_ID_W-1:0]  w_rr_next;

  // Pick the first valid requester at or after the round-robin pointer
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_scan     = '0;
    w_scan_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
      if (w_scan >= c_NUM_EXT) begin
        w_scan = w_scan - c_NUM_EXT;
      end
      w_scan_id = w_scan[c_ID_W-1:0];
      if (!w_found && en && req_valid[w_scan_id]) begin
        w_found    = 1'b1;
        w_grant_id = w_scan_id;
      end
    end
    if (w_found) begin
      w_grant[w_grant_id] = 1'b1;
    end
  end

  // A grant is only ever given to a valid requester, so a grant is a transfer
  assign w_xfer    = w_found;
  assign req_ready = w_grant;
  assign w_rr_next = (w_grant_id == c_LAST_ID) ? '0 : w_grant_id + c_ID_W'(1);

  // Round-robin pointer moves just past the most recent winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Issue stage: capture winner operands, hold them on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_din1 <= '0;
      r_cmp_din2 <= '0;
    end else if (w_xfer) begin
      r_cmp_din1 <= w_din1_arr[w_grant_id];
      r_cmp_din2 <= w_din2_arr[w_grant_id];
    end
  end

  assign cmp_din1 = r_cmp_din1;
  assign cmp_din2 = r_cmp_din2;

  // Tag pipe shifts every cycle in lock-step with the comparator pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= CMP_LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_grant_id;
      for (int s = 1; s <= CMP_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  // Route the comparator result to the requester named by the last tag
  always_comb begin
    rsp_valid = '0;
    rsp_le    = 1'b0;
    rsp_diff  = '0;
    if (r_tag_vld[CMP_LAT]) begin
      rsp_valid[r_tag_id[CMP_LAT]] = 1'b1;
      rsp_le                       = cmp_le;
      rsp_diff                     = cmp_diff;
    end
  end

  assign busy = |r_tag_vld;

`ifdef COMP_ARB_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  // A stall is a cycle with pending requests but no grant (en low)
  assign w_stall = (|req_valid) && !w_xfer;

  // Saturating transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else if (w_xfer && (r_grant_cnt != 32'hFFFF_FFFF)) begin
      r_grant_cnt <= r_grant_cnt + 32'd1;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_arbiter
// Brief    : Self-checking bench for comp_arbiter. A pipelined comparator
//            model drives cmp_le/cmp_diff; a queue-based reference model
//            predicts grants and responses each cycle. Directed scenarios
//            add literal expectations; a random phase follows.
// Options  : COMP_ARB_STATS_EN - also checks grant_cnt / stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 24;
  localparam int CMP_LAT = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_din1;
  logic [NUM_REQ*WIDTH-1:0] req_din2;
  logic [WIDTH-1:0]         cmp_din1;
  logic [WIDTH-1:0]         cmp_din2;
  logic                     cmp_le;
  logic [WIDTH-1:0]         cmp_diff;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_le;
  logic [WIDTH-1:0]         rsp_diff;
  logic                     busy;
`ifdef COMP_ARB_STATS_EN
  logic [31:0]              grant_cnt;
  logic [31:0]              stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  comp_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .CMP_LAT (CMP_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din1  (req_din1),
    .req_din2  (req_din2),
    .cmp_din1  (cmp_din1),
    .cmp_din2  (cmp_din2),
    .cmp_le    (cmp_le),
    .cmp_diff  (cmp_diff),
    .rsp_valid (rsp_valid),
    .rsp_le    (rsp_le),
    .rsp_diff  (rsp_diff),
`ifdef COMP_ARB_STATS_EN
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
    end
  endtask

  // Comparator stand-in: {le, din1-din2} with CMP_LAT cycles of latency
  logic [WIDTH:0] cmp_pipe [CMP_LAT];
  always @(posedge clk) begin
    cmp_pipe[0] <= {(cmp_din1 <= cmp_din2), cmp_din1 - cmp_din2};
    for (int k = 1; k < CMP_LAT; k++) cmp_pipe[k] <= cmp_pipe[k-1];
  end
  assign cmp_le   = cmp_pipe[CMP_LAT-1][WIDTH];
  assign cmp_diff = cmp_pipe[CMP_LAT-1][WIDTH-1:0];

  // Reference model: expected responses with the cycle they are due
  typedef struct {
    int               due;
    int               id;
    logic             le;
    logic [WIDTH-1:0] diff;
  } rsp_t;

  rsp_t             exp_q[$];
  int               m_rr   = 0;
  logic [WIDTH-1:0] m_din1 = '0;
  logic [WIDTH-1:0] m_din2 = '0;
  longint           m_gcnt = 0;
  longint           m_scnt = 0;

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : compare
    int                 win;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rv;
    logic               exp_le;
    logic [WIDTH-1:0]   exp_diff;
    logic               exp_busy;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    rsp_t               r;

    cycle++;
    if (!rst_n) begin
      exp_q.delete();
      m_rr   = 0;
      m_din1 = '0;
      m_din2 = '0;
      m_gcnt = 0;
      m_scnt = 0;
    end

    win = -1;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win < 0 && req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
      end
    end
    exp_ready = (win >= 0) ? (NUM_REQ'(1) << win) : '0;

    exp_busy = (exp_q.size() > 0);
    exp_rv   = '0;
    exp_le   = 1'b0;
    exp_diff = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      exp_rv   = NUM_REQ'(1) << exp_q[0].id;
      exp_le   = exp_q[0].le;
      exp_diff = exp_q[0].diff;
      void'(exp_q.pop_front());
    end

    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("rsp_le",    64'(rsp_le),    64'(exp_le));
    check("rsp_diff",  64'(rsp_diff),  64'(exp_diff));
    check("busy",      64'(busy),      64'(exp_busy));
    check("cmp_din1",  64'(cmp_din1),  64'(m_din1));
    check("cmp_din2",  64'(cmp_din2),  64'(m_din2));
`ifdef COMP_ARB_STATS_EN
    check("grant_cnt", 64'(grant_cnt), 64'(m_gcnt));
    check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
`endif

    if (rst_n) begin
      if (win >= 0) begin
        a       = req_din1[win*WIDTH +: WIDTH];
        b       = req_din2[win*WIDTH +: WIDTH];
        r.due   = cycle + 1 + CMP_LAT;
        r.id    = win;
        r.le    = (a <= b);
        r.diff  = a - b;
        exp_q.push_back(r);
        m_rr    = (win + 1) % NUM_REQ;
        m_din1  = a;
        m_din2  = b;
        m_gcnt++;
      end else if (|req_valid) begin
        m_scnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_din1[i*WIDTH +: WIDTH] = a;
    req_din2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    en        = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin : stim
    logic [NUM_REQ-1:0] t4_exp [10];
    int                 gcount;
    int                 rcount;
    logic [WIDTH-1:0]   a;

    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_din1  = '0;
    req_din2  = '0;
    tick();
    tick();
    check("reset_ready", 64'(req_ready), 64'h0);
    check("reset_rsp",   64'(rsp_valid), 64'h0);
    check("reset_busy",  64'(busy),      64'h0);
    check("reset_din1",  64'(cmp_din1),  64'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Single compare: 5 <= 9, difference -4
    req_valid = 4'b0001;
    set_op(0, 24'd5, 24'd9);
    sample();
    check("t1_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    sample();
    check("t1_rsp_early1", 64'(rsp_valid), 64'h0);
    tick();
    sample();
    check("t1_rsp_early2", 64'(rsp_valid), 64'h0);
    tick();
    sample();
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_le",    64'(rsp_le),    64'h1);
    check("t1_rsp_diff",  64'(rsp_diff),  64'hFFFFFC);
    repeat (3) tick();

    // All requesters continuously valid, din1=i, din2=1
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, WIDTH'(i), 24'd1);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      sample();
      check("t2_grant", 64'(req_ready), 64'(NUM_REQ'(1) << (k % NUM_REQ)));
      if (k >= 3) begin
        check("t2_rsp_valid", 64'(rsp_valid), 64'(NUM_REQ'(1) << ((k - 3) % NUM_REQ)));
        check("t2_rsp_le",    64'(rsp_le),    64'(((k - 3) % NUM_REQ) < 2));
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Requester 2 alone for 10 cycles, equal operands
    do_reset();
    set_op(2, 24'h7FFFFF, 24'h7FFFFF);
    req_valid = 4'b0100;
    gcount = 0;
    rcount = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 10) req_valid = '0;
      sample();
      if (req_ready == 4'b0100) gcount++;
      if (rsp_valid == 4'b0100 && rsp_le && rsp_diff == '0) rcount++;
      tick();
    end
    check("t3_grants",    64'(gcount), 64'd10);
    check("t3_responses", 64'(rcount), 64'd10);

    // Requesters 1 and 3 with en low for cycles 2..4
    do_reset();
    t4_exp = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
               4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    set_op(1, 24'd100, 24'd50);
    set_op(3, 24'd7, 24'd8);
    req_valid = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      en = !(k >= 2 && k <= 4);
      sample();
      check("t4_grant", 64'(req_ready), 64'(t4_exp[k]));
      if (k == 4) check("t4_drain_rsp", 64'(rsp_valid), 64'b1000);
      tick();
    end
    req_valid = '0;
    en        = 1'b1;
    repeat (4) tick();

    // Reset while three compares are in flight
    do_reset();
    set_op(0, 24'd1, 24'd2);
    set_op(1, 24'd3, 24'd2);
    set_op(2, 24'd9, 24'd9);
    req_valid = 4'b0111;
    repeat (3) tick();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("t5_rsp_async",  64'(rsp_valid), 64'h0);
    check("t5_busy_async", 64'(busy),      64'h0);
    check("t5_din1_async", 64'(cmp_din1),  64'h0);
    check("t5_din2_async", 64'(cmp_din2),  64'h0);
    tick();
    tick();
    rst_n  = 1'b1;
    rcount = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (rsp_valid != '0) rcount++;
      tick();
    end
    check("t5_no_rsp_after_reset", 64'(rcount), 64'd0);

`ifdef COMP_ARB_STATS_EN
    // Seven transfers then two stalled cycles
    do_reset();
    set_op(0, 24'd4, 24'd4);
    req_valid = 4'b0001;
    repeat (7) tick();
    en = 1'b0;
    repeat (2) tick();
    req_valid = '0;
    en        = 1'b1;
    check("stats_grant_cnt", 64'(grant_cnt), 64'd7);
    check("stats_stall_cnt", 64'(stall_cnt), 64'd2);
    repeat (4) tick();
`endif

    // Randomized traffic with occasional enable drops and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      req_valid = NUM_REQ'($urandom);
      en        = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        a = WIDTH'($urandom);
        if ($urandom_range(0, 3) == 0) set_op(i, a, a);
        else                           set_op(i, a, WIDTH'($urandom));
      end
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comp_arbiter.md
# comp_arbiter

Round-robin arbiter and sequencer that shares one integer comparator (din1 <= din2, fixed pipeline latency) among NUM_REQ tree-node evaluators. Accepts at most one compare request per cycle, registers the winning operands onto the comparator inputs and tracks the requester ID alongside the comparator pipeline. Routes each result (le flag plus difference) back to the originating requester exactly 1 + CMP_LAT cycles after acceptance. Sits between the per-tree traversal engines and the single comparator_int instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 24, operand width; must match comparator
- CMP_LAT, 2, comparator latency in cycles from registered operands to cmp_le/cmp_diff (>=1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- en  in  1  arbitration enable; low = no new grants, in-flight work completes
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
- req_din1  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_din2  in  NUM_REQ*WIDTH  packed operand B, same packing
- cmp_din1  out  WIDTH  registered operand A to comparator
- cmp_din2  out  WIDTH  registered operand B to comparator
- cmp_le  in  1  comparator result bit (comp_out[0])
- cmp_diff  in  WIDTH  comparator difference (dout)
- rsp_valid  out  NUM_REQ  one-hot response strobe, single cycle
- rsp_le  out  1  result for the strobed requester (din1 <= din2)
- rsp_diff  out  WIDTH  difference din1 - din2 for the strobed requester
- busy  out  1  high while any compare is in flight

## Operation
- Grant: req_ready[i] = en & req_valid[i] & (i is first valid at or after rr_ptr, wrapping). Combinational from req_valid, en, rr_ptr. Transfer occurs on req_valid[i] & req_ready[i].
- rr_ptr: reset 0; after a transfer to i, rr_ptr <= (i+1) mod NUM_REQ; unchanged on cycles without transfer.
- Issue stage: on transfer, cmp_din1/cmp_din2 <= operands of winner, stage-0 tag <= {1, i}. No transfer: operands hold previous value, tag valid <= 0.
- Tag pipe: CMP_LAT further stages of {valid, id} shift every cycle, no stalls; comparator is fully pipelined.
- Response: when the last tag stage is valid, rsp_valid[id] = 1, rsp_le = cmp_le, rsp_diff = cmp_diff (combinational pass-through of comparator outputs, aligned by tag pipe). Otherwise rsp_valid = 0, rsp_le = 0, rsp_diff = 0.
- No response backpressure: requesters must accept rsp_valid in the cycle it is asserted.
- A requester may issue back-to-back; responses return in issue order.
- busy = OR of all tag-stage valid bits.
- en deassertion: req_ready all 0 that cycle; pipeline keeps draining.
- req_valid is sampled every cycle; a requester that drops valid before grant loses no state.

## Timing
- Request-to-response: exactly 1 + CMP_LAT cycles (3 at default). Throughput: 1 compare/cycle aggregate.
- Reset values: req_ready 0, cmp_din1 0, cmp_din2 0, all tag valid 0, rsp_valid 0, rsp_le 0, rsp_diff 0, busy 0, rr_ptr 0.
- Reset mid-operation: all in-flight tags discarded; no rsp_valid for them after reset release.
- Single requester active continuously: granted every cycle.
- All NUM_REQ active: each granted once every NUM_REQ cycles, order rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 -> 0.

## Configuration
- COMP_ARB_STATS_EN defined: adds output grant_cnt (32 bits), incremented on every transfer, saturating at 0xFFFFFFFF, reset 0; plus output stall_cnt (32 bits), incremented on cycles where any req_valid is high but no transfer occurs (en low), saturating, reset 0.
- Not defined: both ports and counters absent; all other behaviour identical.

## Test plan
- Reset, en=1, req 0 valid once with din1=5, din2=9 -> req_ready[0] same cycle; rsp_valid=0001, rsp_le=1, rsp_diff=0xFFFFFC exactly 3 cycles later.
- All 4 requesters valid continuously from reset, din1=i, din2=1 -> grants 0,1,2,3,0,...; responses le=1,1,0,0 repeating, each 3 cycles after its grant.
- Req 2 valid only, din1=din2=0x7FFFFF for 10 cycles -> 10 consecutive grants, 10 consecutive rsp_valid=0100 with rsp_le=1, rsp_diff=0.
- Req 1 and 3 valid, en low for cycles 2..4 -> no req_ready in those cycles, in-flight responses still emerge; grants resume in round-robin order from saved rr_ptr.
- Issue 3 back-to-back compares, assert rst_n=0 one cycle later -> all outputs return to reset values asynchronously, no rsp_valid after release.
- With COMP_ARB_STATS_EN: 7 transfers and 2 en-low stall cycles -> grant_cnt=7, stall_cnt=2.
